// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory responder: burst and response
// encodings, the read/write engine state enums, and the beat address
// generator used by both engines.
package axi_pkg;

  localparam int AXI_ADDR_W = 36;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

  // Address of the beat following addr. The reserved burst type falls
  // through to INCR. WRAP keeps the upper bits outside the
  // (len+1)<<size window and lets the lower bits roll over.
  function automatic axi_addr_t axi_next_addr(input axi_addr_t  addr,
                                              input logic [2:0] size,
                                              input logic [7:0] len,
                                              input logic [1:0] burst);
    axi_addr_t step;
    axi_addr_t incr;
    axi_addr_t mask;
    step = axi_addr_t'(1) << size;
    incr = addr + step;
    mask = ((axi_addr_t'(len) + axi_addr_t'(1)) << size) - axi_addr_t'(1);
    case (burst)
      BURST_FIXED: axi_next_addr = addr;
      BURST_WRAP:  axi_next_addr = (addr & ~mask) | (incr & mask);
      default:     axi_next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM for the AXI memory responder.
// Ports:
//   clk              clock
//   we/waddr/wdata/wstrb  write port, byte enables per 8-bit lane
//   re/raddr         synchronous read request
//   rdata            registered read data, valid the cycle after re;
//                    holds its value while re is low
// A same-cycle read and write to one word returns the old contents.
module axi_mem_ram #(
  parameter int WORD_AW = 13
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [63:0]        wdata,
  input  logic [7:0]         wstrb,
  input  logic               re,
  input  logic [WORD_AW-1:0] raddr,
  output logic [63:0]        rdata
);

  logic [63:0] mem [2**WORD_AW];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave that terminates read and write bursts on an internal
// byte-addressed RAM of 2^MEM_LOG2 bytes. Independent read and write
// engines, one outstanding burst each.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   s_axi_aw*              write address channel
//   s_axi_w*               write data channel
//   s_axi_b*               write response channel
//   s_axi_ar*              read address channel
//   s_axi_r*               read data channel
//   s_axi_{ar,aw}{cache,lock,prot,qos}  accepted and ignored
// Build option AXI_MEM_RANGE_CHECK_EN: bursts starting outside
// [BASE_ADDR, BASE_ADDR + 2^MEM_LOG2) answer DECERR, writes are dropped
// and reads return 0. Without it the memory aliases over all addresses.
//
// Write engine
//   state  | meaning
//   W_IDLE | awready high, waiting for AW
//   W_DATA | wready high, one beat per W handshake
//   W_RESP | bvalid high until bready
// Read engine
//   state   | meaning
//   R_IDLE  | arready high, waiting for AR
//   R_FETCH | RAM read issued for the current beat
//   R_DATA  | rvalid high, beat held until rready
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 36,
  parameter int                MEM_LOG2  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(36'h8_0000_0000)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic [3:0]          s_axi_awcache,
  input  logic                s_axi_awlock,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [3:0]          s_axi_arcache,
  input  logic                s_axi_arlock,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int WORD_AW = MEM_LOG2 - 3;

  w_state_e            w_state_q, w_state_d;
  logic                aw_ready_q, aw_ready_d;
  logic [ID_W-1:0]     w_id_q, w_id_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [7:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]          w_size_q, w_size_d;
  logic [1:0]          w_burst_q, w_burst_d, w_resp_q, w_resp_d;
  logic                w_drop_q, w_drop_d;

  r_state_e            r_state_q, r_state_d;
  logic                ar_ready_q, ar_ready_d;
  logic [ID_W-1:0]     r_id_q, r_id_d;
  logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
  logic [7:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]          r_size_q, r_size_d;
  logic [1:0]          r_burst_q, r_burst_d, r_resp_q, r_resp_d;
  logic                r_zero_q, r_zero_d;

  logic                aw_oor, ar_oor, w_last, r_last, mem_we, mem_re;
  logic [63:0]         mem_rdata;

`ifdef AXI_MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + ((ADDR_W+1)'(1) << MEM_LOG2);
  assign aw_oor = ({1'b0, s_axi_awaddr} < WIN_LO) || ({1'b0, s_axi_awaddr} >= WIN_HI);
  assign ar_oor = ({1'b0, s_axi_araddr} < WIN_LO) || ({1'b0, s_axi_araddr} >= WIN_HI);
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi_awcache, s_axi_awlock, s_axi_awprot, s_axi_awqos,
                       s_axi_arcache, s_axi_arlock, s_axi_arprot, s_axi_arqos,
                       BASE_ADDR};

  assign w_last = (w_cnt_q == w_len_q);
  assign r_last = (r_cnt_q == r_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_resp_d  = w_resp_q;
    w_drop_d  = w_drop_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && aw_ready_q) begin
          w_id_d    = s_axi_awid;
          w_addr_d  = s_axi_awaddr;
          w_len_d   = s_axi_awlen;
          w_size_d  = s_axi_awsize;
          w_burst_d = s_axi_awburst;
          w_cnt_d   = 8'd0;
          w_drop_d  = aw_oor || (s_axi_awsize > 3'd3);
          if (aw_oor)                                              w_resp_d = RESP_DECERR;
          else if ((s_axi_awsize > 3'd3) || (s_axi_awburst == 2'b11)) w_resp_d = RESP_SLVERR;
          else                                                     w_resp_d = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we   = !w_drop_q;
          w_addr_d = ADDR_W'(axi_next_addr(AXI_ADDR_W'(w_addr_q), w_size_q, w_len_q, w_burst_q));
          w_cnt_d  = w_cnt_q + 8'd1;
          // The burst length is set by awlen; a misplaced wlast only taints the response.
          if ((s_axi_wlast != w_last) && (w_resp_q == RESP_OKAY)) w_resp_d = RESP_SLVERR;
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_resp_d  = r_resp_q;
    r_zero_d  = r_zero_q;
    mem_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && ar_ready_q) begin
          r_id_d    = s_axi_arid;
          r_addr_d  = s_axi_araddr;
          r_len_d   = s_axi_arlen;
          r_size_d  = s_axi_arsize;
          r_burst_d = s_axi_arburst;
          r_cnt_d   = 8'd0;
          r_zero_d  = ar_oor || (s_axi_arsize > 3'd3);
          if (ar_oor)                                              r_resp_d = RESP_DECERR;
          else if ((s_axi_arsize > 3'd3) || (s_axi_arburst == 2'b11)) r_resp_d = RESP_SLVERR;
          else                                                     r_resp_d = RESP_OKAY;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        mem_re    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = ADDR_W'(axi_next_addr(AXI_ADDR_W'(r_addr_q), r_size_q, r_len_q, r_burst_q));
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_cnt_q    <= '0;
      w_resp_q   <= '0;
      w_drop_q   <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      r_resp_q   <= '0;
      r_zero_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= aw_ready_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_size_q   <= w_size_d;
      w_burst_q  <= w_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_resp_q   <= w_resp_d;
      w_drop_q   <= w_drop_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_size_q   <= r_size_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_resp_q   <= r_resp_d;
      r_zero_q   <= r_zero_d;
    end
  end

  axi_mem_ram #(.WORD_AW(WORD_AW)) u_ram (
    .clk   (aclk),
    .we    (mem_we),
    .waddr (w_addr_q[MEM_LOG2-1:3]),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (mem_re),
    .raddr (r_addr_q[MEM_LOG2-1:3]),
    .rdata (mem_rdata)
  );

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = w_resp_q;

  assign s_axi_arready = ar_ready_q;
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rlast   = (r_state_q == R_DATA) && r_last;
  assign s_axi_rdata   = ((r_state_q == R_DATA) && !r_zero_q) ? mem_rdata : '0;

endmodule
